// File: rtl/cmp_mon_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cmp_mon_pkg
// Description : Relation encoding and comparator flag decode for the monitor.
// Revision    : 1.0 - initial release
// ============================================================================
package cmp_mon_pkg;

  localparam logic [1:0] c_st_unknown = 2'b00;
  localparam logic [1:0] c_st_equal   = 2'b01;
  localparam logic [1:0] c_st_above   = 2'b10;
  localparam logic [1:0] c_st_below   = 2'b11;

  typedef struct packed {
    logic       legal;
    logic [1:0] rel;
  } flag_dec_t;

  // Exactly one flag high is legal; anything else reports UNKNOWN/illegal.
  function automatic flag_dec_t decode_flags(input logic qagb,
                                             input logic qasb,
                                             input logic qaeb);
    flag_dec_t d;
    d.legal = 1'b0;
    d.rel   = c_st_unknown;
    case ({qagb, qasb, qaeb})
      3'b100: begin d.legal = 1'b1; d.rel = c_st_above; end
      3'b010: begin d.legal = 1'b1; d.rel = c_st_below; end
      3'b001: begin d.legal = 1'b1; d.rel = c_st_equal; end
      default: begin d.legal = 1'b0; d.rel = c_st_unknown; end
    endcase
    return d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Up-counter that sticks at all-ones; clear beats increment.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CLR,
  input  logic             INC,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] c_max = '1;

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_count <= '0;
    end else if (CLR) begin
      r_count <= '0;
    end else if (INC && (r_count != c_max)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/cmp_event_monitor.sv
`default_nettype none
// ============================================================================
// Module      : cmp_event_monitor
// Description : Debounces comparator flags into a relation state and counts
//               entries into ABOVE/BELOW, flagging illegal flag combinations.
// Revision    : 1.0 - initial release
// ============================================================================
module cmp_event_monitor
  import cmp_mon_pkg::*;
#(
  parameter int DEBOUNCE = 4,
  parameter int CNT_W    = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             SAMPLE_EN,
  input  logic             QAGB,
  input  logic             QASB,
  input  logic             QAEB,
  input  logic             CLR_CNT,
  output logic [1:0]       STATE,
  output logic             CHANGE,
  output logic             ALARM,
  output logic [CNT_W-1:0] ABOVE_CNT,
  output logic [CNT_W-1:0] BELOW_CNT,
  output logic             ERR
);

  localparam logic [3:0] c_debounce = 4'(DEBOUNCE);

  flag_dec_t  w_dec;
  logic       w_legal;
  logic       w_illegal;
  logic [3:0] w_run_nxt;
  logic [1:0] w_cand_nxt;
  logic [1:0] w_state_nxt;
  logic       w_fire;
  logic       w_inc_above;
  logic       w_inc_below;

  logic [1:0] r_state;
  logic [1:0] r_cand;
  logic [3:0] r_run;
  logic       r_change;
  logic       r_err;

  assign w_dec     = decode_flags(QAGB, QASB, QAEB);
  assign w_legal   = SAMPLE_EN & w_dec.legal;
  assign w_illegal = SAMPLE_EN & ~w_dec.legal;

  // Illegal samples and idle cycles leave the run tracker untouched.
  always_comb begin
    w_cand_nxt  = r_cand;
    w_run_nxt   = r_run;
    w_state_nxt = r_state;
    w_fire      = 1'b0;
    if (w_legal) begin
      w_cand_nxt = w_dec.rel;
      if (w_dec.rel == r_cand) begin
        w_run_nxt = (r_run >= c_debounce) ? c_debounce : r_run + 4'd1;
      end else begin
        w_run_nxt = 4'd1;
      end
      if ((w_run_nxt == c_debounce) && (w_dec.rel != r_state)) begin
        w_fire      = 1'b1;
        w_state_nxt = w_dec.rel;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state  <= c_st_unknown;
      r_cand   <= c_st_unknown;
      r_run    <= 4'd0;
      r_change <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cand   <= w_cand_nxt;
      r_run    <= w_run_nxt;
      r_change <= w_fire;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_err <= 1'b0;
    end else if (CLR_CNT) begin
      r_err <= 1'b0;
    end else if (w_illegal) begin
      r_err <= 1'b1;
    end
  end

  assign w_inc_above = w_fire & (w_dec.rel == c_st_above);
  assign w_inc_below = w_fire & (w_dec.rel == c_st_below);

  sat_counter #(
    .WIDTH (CNT_W)
  ) u_above_cnt (
    .CLK   (CLK),
    .RST   (RST),
    .CLR   (CLR_CNT),
    .INC   (w_inc_above),
    .count (ABOVE_CNT)
  );

  sat_counter #(
    .WIDTH (CNT_W)
  ) u_below_cnt (
    .CLK   (CLK),
    .RST   (RST),
    .CLR   (CLR_CNT),
    .INC   (w_inc_below),
    .count (BELOW_CNT)
  );

  assign STATE  = r_state;
  assign CHANGE = r_change;
  assign ERR    = r_err;
  assign ALARM  = (r_state == c_st_above);

endmodule
`default_nettype wire

// File: doc/cmp_event_monitor.md
CMP_EVENT_MONITOR -- requirements
Module: cmp_event_monitor

Interface
REQ-001 Parameter: DEBOUNCE, 4, consecutive identical legal samples required to change state; legal range 1..15.
REQ-002 Parameter: CNT_W, 8, width of the event counters.
REQ-003 Clocking: one clock, CLK; reset RST is synchronous and active-high.
REQ-004 Port: CLK  input  1  rising-edge clock.
REQ-005 Port: RST  input  1  synchronous active-high reset.
REQ-006 Port: SAMPLE_EN  input  1  high = sample the comparator flags this cycle.
REQ-007 Port: QAGB  input  1  upstream 8-bit comparator "A greater than B" flag.
REQ-008 Port: QASB  input  1  upstream comparator "A less than B" flag.
REQ-009 Port: QAEB  input  1  upstream comparator "A equal to B" flag.
REQ-010 Port: CLR_CNT  input  1  synchronous clear of counters and ERR.
REQ-011 Port: STATE  output  2  debounced relation: 00 UNKNOWN, 01 EQUAL, 10 ABOVE, 11 BELOW.
REQ-012 Port: CHANGE  output  1  one-cycle pulse on every STATE change.
REQ-013 Port: ALARM  output  1  high while STATE = ABOVE.
REQ-014 Port: ABOVE_CNT  output  CNT_W  count of entries into ABOVE.
REQ-015 Port: BELOW_CNT  output  CNT_W  count of entries into BELOW.
REQ-016 Port: ERR  output  1  sticky illegal-flag indicator.

Function
REQ-017 Legal sample: SAMPLE_EN=1 and exactly one of QAGB/QASB/QAEB high; map QAGB->ABOVE, QASB->BELOW, QAEB->EQUAL.
REQ-018 Illegal sample (SAMPLE_EN=1, zero or more than one flag high): set ERR on the next edge; no change to run tracking, STATE or counters.
REQ-019 SAMPLE_EN=0: all internal state holds, CHANGE=0.
REQ-020 Run tracker: internal CAND (2 bits) and RUN (4 bits); on a legal sample equal to CAND, RUN increments, saturating at DEBOUNCE; otherwise CAND<=sample and RUN<=1.
REQ-021 State change: when a legal sample makes the updated RUN equal DEBOUNCE and sample differs from STATE, STATE<=sample on that same edge; CHANGE=1 for exactly the following cycle.
REQ-022 Latency: new STATE visible after the edge of the DEBOUNCE-th consecutive identical legal sample; DEBOUNCE=1 gives one-edge latency.
REQ-023 Continued identical samples after the state change produce no further CHANGE pulses.
REQ-024 Illegal samples interleaved in a run do not break the run (REQ-018); SAMPLE_EN=0 gaps do not break the run.
REQ-025 ABOVE_CNT increments on each STATE entry into ABOVE; BELOW_CNT on each entry into BELOW; both saturate at 2^CNT_W-1, never wrap.
REQ-026 CLR_CNT=1: ABOVE_CNT, BELOW_CNT, ERR <= 0 on that edge; clear wins over a simultaneous increment or illegal sample; STATE, CAND, RUN unaffected.
REQ-027 ALARM is combinational decode of the STATE register only (no extra latency).

Reset
REQ-028 RST=1 at an edge: STATE=UNKNOWN, CAND=UNKNOWN, RUN=0, CHANGE=0, ABOVE_CNT=0, BELOW_CNT=0, ERR=0; ALARM=0 follows.
REQ-029 RST has priority over SAMPLE_EN and CLR_CNT; reset mid-run discards the partial run; no CHANGE pulse is generated by reset.

Structure
REQ-030 Shared package cmp_mon_pkg holds the 2-bit state encoding constants and the flag-decode/legality function.
REQ-031 One sub-module sat_counter (parameter width; inputs CLK, RST, CLR, INC; output count) instantiated twice for ABOVE_CNT and BELOW_CNT.
REQ-032 All outputs except ALARM are registered; no latches; single clock domain.

Verification
REQ-033 Reset then 4 samples QAGB=1 (DEBOUNCE=4) -> STATE=10 after 4th edge, CHANGE one cycle, ALARM=1, ABOVE_CNT=1.
REQ-034 3x QAGB, 1x QAEB, 3x QAGB -> STATE stays 00, CHANGE never pulses; 4th consecutive QAGB then flips STATE to 10.
REQ-035 Flags 110 then 000 with SAMPLE_EN=1 inside a QASB run of 4 -> ERR=1 sticky, STATE=11 after 4th legal QASB, BELOW_CNT=1.
REQ-036 CNT_W=2, alternate 4xQAGB/4xQASB five times -> ABOVE_CNT and BELOW_CNT saturate at 3; CLR_CNT together with a 5th ABOVE entry -> ABOVE_CNT=0.
REQ-037 RST asserted after 2 of 4 QAEB samples, then 2 more QAEB -> STATE stays 00; 4 further QAEB -> STATE=01.
REQ-038 DEBOUNCE=1, QASB/QAGB alternating each cycle with SAMPLE_EN=1 -> STATE toggles every edge, CHANGE high continuously.
